// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_REQ   = 2'b01,
        FETCH_VALID = 2'b10,
        FETCH_FAULT = 2'b11
    } fetch_state_t;

    // Sticky fault cause encodings, as seen on the fault_cause output.
    typedef enum logic [1:0] {
        FETCH_FC_NONE     = 2'b00,
        FETCH_FC_MISALIGN = 2'b01,
        FETCH_FC_BUSERR   = 2'b10,
        FETCH_FC_TIMEOUT  = 2'b11
    } fetch_cause_t;

    // addi x0,x0,0: the IR contents whenever no real instruction is held.
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

    // Instruction fetches must be word aligned.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: req/ack handshake with variable latency.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    // The fetch unit issues requests and receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        input  imem_err
    );

    // The memory side answers requests.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        output imem_err
    );
endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Transaction watchdog counter: load/clear/increment with a terminal-count
// flag that is high in the cycle whose increment would reach LIMIT.
module fetch_timeout_ctr #(
    parameter  int unsigned LIMIT = 16,
    localparam int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Counter register; clear wins over load, load wins over increment.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = i_inc && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns PC and IR, issues one word read per
// instruction and holds the IR stable while the control unit executes it.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = FETCH_NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_fetch_req,
    input  logic                    i_pc_load,
    input  logic [31:0]             i_pc_next,
    input  logic                    i_fault_clr,
    instr_fetch_unit_if.master      imem,
    output logic [31:0]             o_instr_code,
    output logic [31:0]             o_pc,
    output logic                    o_instr_valid,
    output logic                    o_fetch_busy,
    output logic                    o_fault,
    output logic [1:0]              o_fault_cause
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    fetch_cause_t r_cause;
    fetch_cause_t w_next_cause;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic [31:0]  r_addr;
    logic [31:0]  w_ea;
    logic         w_accepting;
    logic         w_issue;
    logic         w_timeout;

    // PC and fetch requests are only honoured between transactions.
    assign w_accepting = (r_state == FETCH_IDLE) || (r_state == FETCH_VALID);
    assign w_ea        = i_pc_load ? i_pc_next : r_pc;
    assign w_issue     = w_accepting && i_fetch_req && is_word_aligned(w_ea);

    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_next_state != FETCH_REQ),
        .i_load     (1'b0),
        .i_load_val ({CW{1'b0}}),
        .i_inc      (r_state == FETCH_REQ),
        .o_tc       (w_timeout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_IDLE;
            r_cause <= FETCH_FC_NONE;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
        end
    end

    // Next-state and fault-cause selection; bus error beats ack beats timeout.
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        unique case (r_state)
            FETCH_IDLE, FETCH_VALID: begin
                if (i_fetch_req) begin
                    if (is_word_aligned(w_ea)) begin
                        w_next_state = FETCH_REQ;
                    end else begin
                        w_next_state = FETCH_FAULT;
                        w_next_cause = FETCH_FC_MISALIGN;
                    end
                end else if (i_pc_load) begin
                    w_next_state = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (imem.imem_err) begin
                    w_next_state = FETCH_FAULT;
                    w_next_cause = FETCH_FC_BUSERR;
                end else if (imem.imem_ack) begin
                    w_next_state = FETCH_VALID;
                end else if (w_timeout) begin
                    w_next_state = FETCH_FAULT;
                    w_next_cause = FETCH_FC_TIMEOUT;
                end
            end
            FETCH_FAULT: begin
                if (i_fault_clr) begin
                    w_next_state = FETCH_IDLE;
                    w_next_cause = FETCH_FC_NONE;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
                w_next_cause = FETCH_FC_NONE;
            end
        endcase
    end

    // PC register: written only by PCEn while no transaction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_accepting && i_pc_load) begin
            r_pc <= i_pc_next;
        end
    end

    // Request address: captured when a fetch is issued, held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= RESET_PC;
        end else if (w_issue) begin
            r_addr <= w_ea;
        end
    end

    // IR: loaded from the bus on a clean ack, forced to NOP on entering FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= NOP_INSTR;
        end else if ((r_state == FETCH_REQ) && (w_next_state == FETCH_VALID)) begin
            r_ir <= imem.imem_rdata;
        end else if ((r_state != FETCH_FAULT) && (w_next_state == FETCH_FAULT)) begin
            r_ir <= NOP_INSTR;
        end
    end

    // Status outputs decode straight from registered state, so reset clears them at once.
    assign imem.imem_req  = (r_state == FETCH_REQ);
    assign imem.imem_addr = r_addr;
    assign o_instr_code   = r_ir;
    assign o_pc           = r_pc;
    assign o_instr_valid  = (r_state == FETCH_VALID);
    assign o_fetch_busy   = (r_state == FETCH_REQ);
    assign o_fault        = (r_state == FETCH_FAULT);
    assign o_fault_cause  = r_cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: transaction-level reference model of the fetch stage
// with directed scenarios followed by randomized fetch/load/clear traffic.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        fault_clr;
    logic [31:0] instr_code;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fault;
    logic [1:0]  fault_cause;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TMO),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_fetch_req   (fetch_req),
        .i_pc_load     (pc_load),
        .i_pc_next     (pc_next),
        .i_fault_clr   (fault_clr),
        .imem          (bus),
        .o_instr_code  (instr_code),
        .o_pc          (pc),
        .o_instr_valid (instr_valid),
        .o_fetch_busy  (fetch_busy),
        .o_fault       (fault),
        .o_fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_fault;
    logic [1:0]  m_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all outputs against the model while no transaction is in flight.
    task automatic check_state(input string tag);
        check({tag, ".pc"},    pc,                 m_pc);
        check({tag, ".ir"},    instr_code,         m_ir);
        check({tag, ".valid"}, 32'(instr_valid),   32'(m_valid));
        check({tag, ".fault"}, 32'(fault),         32'(m_fault));
        check({tag, ".cause"}, 32'(fault_cause),   32'(m_cause));
        check({tag, ".busy"},  32'(fetch_busy),    32'd0);
        check({tag, ".req"},   32'(bus.imem_req),  32'd0);
        check({tag, ".addr"},  bus.imem_addr,      m_addr);
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_ir    = NOP;
        m_addr  = RESET_PC;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_cause = 2'b00;
    endtask

    // One fetch: memory answers after wait_n wait cycles (>= TMO means never).
    // Called just after a negedge; returns just after a negedge.
    task automatic do_fetch(input logic load, input logic [31:0] next, input int wait_n,
                            input logic use_err, input logic [31:0] data);
        logic [31:0] ea;
        logic [31:0] r;
        fetch_req = 1'b1;
        pc_load   = load;
        pc_next   = next;
        if (m_fault) begin
            @(negedge clk);
            fetch_req = 1'b0;
            pc_load   = 1'b0;
            check_state("fault_hold");
            return;
        end
        if (load) m_pc = next;
        ea      = m_pc;
        m_valid = 1'b0;
        if (ea[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_cause = 2'b01;
            m_ir    = NOP;
            @(negedge clk);
            fetch_req = 1'b0;
            pc_load   = 1'b0;
            check_state("misalign");
            return;
        end
        m_addr = ea;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            check("req.req",  32'(bus.imem_req), 32'd1);
            check("req.busy", 32'(fetch_busy),   32'd1);
            check("req.addr", bus.imem_addr,     ea);
            check("req.pc",   pc,                m_pc);
            // Inputs that must be ignored while the transaction is open.
            r         = $urandom;
            fetch_req = r[0];
            pc_load   = r[1];
            pc_next   = $urandom;
            if (k == wait_n) begin
                bus.imem_rdata = data;
                bus.imem_ack   = 1'b1;
                bus.imem_err   = use_err;
            end
            @(negedge clk);
            fetch_req    = 1'b0;
            pc_load      = 1'b0;
            bus.imem_ack = 1'b0;
            bus.imem_err = 1'b0;
            if (k == wait_n) break;
        end
        if (wait_n >= TMO) begin
            m_fault = 1'b1;
            m_cause = 2'b11;
            m_ir    = NOP;
        end else if (use_err) begin
            m_fault = 1'b1;
            m_cause = 2'b10;
            m_ir    = NOP;
        end else begin
            m_ir    = data;
            m_valid = 1'b1;
        end
        check_state("fetch_done");
    endtask

    task automatic do_load_only(input logic [31:0] next);
        pc_load = 1'b1;
        pc_next = next;
        if (!m_fault) begin
            m_pc    = next;
            m_valid = 1'b0;
        end
        @(negedge clk);
        pc_load = 1'b0;
        check_state("load_only");
    endtask

    task automatic do_clear();
        fault_clr = 1'b1;
        if (m_fault) begin
            m_fault = 1'b0;
            m_cause = 2'b00;
        end
        @(negedge clk);
        fault_clr = 1'b0;
        check_state("clear");
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] nx;
        int          op;

        reset          = 1'b1;
        fetch_req      = 1'b0;
        pc_load        = 1'b0;
        pc_next        = '0;
        fault_clr      = 1'b0;
        bus.imem_rdata = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_err   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_state("reset");

        // Directed scenarios.
        do_fetch(1'b0, 32'h0, 0, 1'b0, 32'h0050_0093);
        do_fetch(1'b1, 32'h4, 3, 1'b0, 32'h0010_0113);
        do_fetch(1'b1, 32'h6, 0, 1'b0, 32'hDEAD_BEEF);
        do_clear();
        do_fetch(1'b1, 32'h8, TMO + 4, 1'b0, 32'h1234_5678);
        do_clear();
        do_fetch(1'b1, 32'hC, 15, 1'b0, 32'h0AAA_AAA3);
        do_fetch(1'b0, 32'h0, 2, 1'b1, 32'h5555_5555);
        do_clear();
        do_load_only(32'h100);
        do_fetch(1'b0, 32'h0, 1, 1'b0, 32'h0000_1037);
        @(negedge clk);
        check_state("valid_hold");

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            r  = $urandom;
            nx = {r[31:2], 2'b00};
            if ($urandom_range(0, 5) == 0) nx[0] = 1'b1;
            op = $urandom_range(0, 9);
            if (m_fault && op < 4) begin
                do_clear();
            end else if (op < 7) begin
                do_fetch(r[31] ^ r[0], nx, $urandom_range(0, TMO + 3),
                         ($urandom_range(0, 7) == 0), $urandom);
            end else if (op < 9) begin
                do_load_only(nx);
            end else begin
                @(negedge clk);
                check_state("idle");
            end
        end

        // Reset asserted mid-transaction, followed by a stray ack.
        if (m_fault) do_clear();
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_next   = 32'h0000_0040;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        check("rst.req_before", 32'(bus.imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst.req_async", 32'(bus.imem_req), 32'd0);
        check("rst.pc_async",  pc,                RESET_PC);
        model_reset();
        @(negedge clk);
        reset          = 1'b0;
        bus.imem_rdata = 32'hCAFE_F00D;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check_state("late_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multi-cycle fetch stage directly upstream of the RV32I control unit and datapath. Owns the PC and the instruction register (IR). Issues one word-aligned read per instruction to instruction memory over a req/ack handshake with variable latency. Holds instr_code stable while the control unit steps through DECODE/EXE/MEM/WB; the PC is updated only on pc_load, which is driven by PCEn.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT_CYCLES, 16, max cycles in REQ without ack/err before fault; counter width $clog2(TIMEOUT_CYCLES+1)
NOP_INSTR, 32'h0000_0013, IR value after reset and after fault (addi x0,x0,0)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
fetch_req  input  1  pulse: start a fetch at the effective PC
pc_load  input  1  PC write enable (PCEn)
pc_next  input  32  next PC from datapath (PC+4, branch or jump target)
fault_clr  input  1  clears the sticky fault; returns to IDLE
imem_req  output  1  instruction memory request
imem_addr  output  32  request address; stable while imem_req=1
imem_rdata  input  32  read data; valid in the cycle imem_ack=1
imem_ack  input  1  read complete
imem_err  input  1  bus error; takes precedence over imem_ack in the same cycle
instr_code  output  32  IR contents, feeds instrCode
pc  output  32  current PC
instr_valid  output  1  IR holds the instruction fetched at pc
fetch_busy  output  1  high in REQ
fault  output  1  sticky fetch fault
fault_cause  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout

Behaviour:
- Reset (asynchronous): pc=RESET_PC, IR=NOP_INSTR, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, fault=0, fault_cause=00, timeout counter=0.
- Effective address: ea = pc_load ? pc_next : pc.
- States:
  - IDLE
  - REQ
  - VALID
  - FAULT
- IDLE / VALID:
  - pc_load=1 -> pc<=pc_next on the clock edge.
  - fetch_req=1 with ea[1:0]!=0 -> FAULT, cause 01, no bus request.
  - fetch_req=1 with ea aligned -> REQ next cycle with imem_addr=ea, imem_req=1, instr_valid=0.
  - pc_load without fetch_req in VALID -> instr_valid<=0, IDLE.
  - In VALID with neither input: hold.
- REQ: imem_req=1, imem_addr held, counter increments every cycle.
  - imem_err -> FAULT, cause 10.
  - imem_ack -> IR<=imem_rdata, instr_valid=1 from the next cycle, VALID.
  - Counter reaches TIMEOUT_CYCLES with no ack -> FAULT, cause 11, imem_req drops.
  - pc_load and fetch_req are ignored in REQ. PC and address never change mid-transaction.
  - Counter clears on leaving REQ.
- Fetch latency: ack in the same cycle REQ is entered -> instr_valid one cycle after the fetch_req edge. Ack after N wait cycles -> latency N+1.
- FAULT: imem_req=0, instr_valid=0, IR=NOP_INSTR, fault=1, cause held.
  - fetch_req and pc_load are ignored.
  - fault_clr -> IDLE, fault=0, cause=00; pc is unchanged.
- Simultaneous pc_load and fetch_req in IDLE/VALID: pc<=pc_next and the request is issued to pc_next in the same edge.
- Reset asserted mid-REQ: imem_req deasserts asynchronously. A late ack after reset is ignored (state is IDLE).
- instr_code is a register output only; no combinational path from imem_rdata.
- Arithmetic: no adder inside the block; PC increment and targets come from the datapath.

Decomposition:
- Shared package (alongside defines):
  - fetch state enum
  - fault_cause encodings FETCH_FC_NONE/MISALIGN/BUSERR/TIMEOUT
  - NOP_INSTR constant
- One natural sub-module: fetch_timeout_ctr (load/clear/increment, terminal-count flag), reusable for the data-memory stage.
- PC and IR registers stay in the top module.

Test Plan:
- Reset release, fetch_req with ack on the same cycle as the request and imem_rdata=32'h00500093 -> imem_addr=0, instr_code=32'h00500093, instr_valid high one cycle after the request edge.
- pc_load with pc_next=32'h0000_0004 plus fetch_req, ack after 3 wait cycles -> imem_addr stays 4 for 4 cycles, fetch_busy high 4 cycles, then instr_valid=1.
- fetch_req with pc_next=32'h0000_0006 and pc_load -> no imem_req, fault=1, cause=01, instr_code=32'h00000013.
- No ack for 16 REQ cycles -> fault cause=11 at cycle 16, imem_req low. fault_clr -> IDLE, fault=0.
- imem_err and imem_ack in the same cycle -> fault cause=10, IR not loaded.
- Reset asserted during REQ -> imem_req low immediately, pc=RESET_PC; a following ack produces no instr_valid.
